// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types, default sizes and lane helpers for the operand skew feeder
package feeder_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int FEEDER_SIZE       = 8;
  localparam int FEEDER_DATA_WIDTH = 16;
  localparam int FEEDER_K          = 8;
  localparam int STREAM_LEN        = FEEDER_K + FEEDER_SIZE - 1;

  // Lane k (1..SIZE) occupies bits [k*dw-1 -: dw]; return its low bit.
  function automatic int lane_lo(input int k, input int data_width);
    return (k - 1) * data_width;
  endfunction

  // Streaming cycles needed to drain k beats through a size-lane skew.
  function automatic int stream_len(input int k, input int size);
    return k + size - 1;
  endfunction

endpackage

// File: rtl/operand_skew_feeder_if.sv
// rtl/operand_skew_feeder_if.sv - beat handshake and skewed lane bus of the operand feeder
interface operand_skew_feeder_if #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [SIZE*DATA_WIDTH-1:0] in_a;
  logic [SIZE*DATA_WIDTH-1:0] in_b;
  logic [SIZE*DATA_WIDTH-1:0] out_left;
  logic [SIZE*DATA_WIDTH-1:0] out_up;
  logic                       out_active;
  logic                       tile_start;
  logic                       tile_done;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, out_left, out_up, out_active, tile_start, tile_done
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, out_left, out_up, out_active, tile_start, tile_done
  );
endinterface

// File: rtl/feeder_lane_buffer.sv
// rtl/feeder_lane_buffer.sv - K-deep beat store for one operand bus with per-lane skewed read
module feeder_lane_buffer
  import feeder_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 16,
  parameter int K          = 8,
  parameter int CNT_W      = 4,
  parameter int BEAT_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [BEAT_W-1:0]          wr_idx,
  input  logic [SIZE*DATA_WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0]           rd_t,
  output logic [SIZE*DATA_WIDTH-1:0] rd_lanes
);
  localparam int W = SIZE * DATA_WIDTH;

  logic [W-1:0] mem_q [K];
  logic [W-1:0] mem_d [K];

  // Next contents: the beat being written lands in its slot; reads see it the same cycle.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < K; i++) begin
      if (wr_en && (wr_idx == BEAT_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Slot storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar k = 1; k <= SIZE; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_val;

    // Lane k lags by SIZE-k cycles; indices outside 0..K-1 read as zero.
    always_comb begin
      lane_val = '0;
      for (int j = 0; j < K; j++) begin
        if (int'(rd_t) - (SIZE - k) == j) begin
          lane_val = mem_d[j][lane_lo(k, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end

    assign rd_lanes[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH] = lane_val;
  end

endmodule

// File: rtl/operand_skew_feeder.sv
// rtl/operand_skew_feeder.sv - collects K operand beats and replays them skewed; FEEDER_PINGPONG_EN adds a second buffer set
module operand_skew_feeder
  import feeder_pkg::*;
#(
  parameter int SIZE       = FEEDER_SIZE,
  parameter int DATA_WIDTH = FEEDER_DATA_WIDTH,
  parameter int K          = FEEDER_K,
  parameter int CNT_W      = $clog2(K + SIZE)
) (
  input logic                  clk,
  input logic                  rst,
  operand_skew_feeder_if.slave bus
);
  localparam int W      = SIZE * DATA_WIDTH;
  localparam int LEN    = stream_len(K, SIZE);
  localparam int BEAT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0]  T_LAST    = CNT_W'(LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(K - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  t_q, t_d;
  logic              in_ready_q, in_ready_d;
  logic              out_active_q, out_active_d;
  logic              tile_start_q, tile_start_d;
  logic              tile_done_q, tile_done_d;
  logic [W-1:0]      out_left_q, out_left_d;
  logic [W-1:0]      out_up_q, out_up_d;
  logic [W-1:0]      rd_a, rd_b;
  logic              accept;
  logic              last_beat;

  assign accept    = bus.in_valid && in_ready_q;
  assign last_beat = accept && (beat_cnt_q == BEAT_LAST);

`ifdef FEEDER_PINGPONG_EN
  logic         wr_sel_q, wr_sel_d;
  logic         rd_sel_q, rd_sel_d;
  logic         idle_full_q, idle_full_d;
  logic [W-1:0] rd_a0, rd_a1, rd_b0, rd_b1;

  feeder_lane_buffer #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .K(K), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) u_buf_a0 (
    .clk(clk), .rst(rst), .wr_en(accept && !wr_sel_q), .wr_idx(beat_cnt_q),
    .wr_data(bus.in_a), .rd_t(t_d), .rd_lanes(rd_a0));
  feeder_lane_buffer #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .K(K), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) u_buf_a1 (
    .clk(clk), .rst(rst), .wr_en(accept && wr_sel_q), .wr_idx(beat_cnt_q),
    .wr_data(bus.in_a), .rd_t(t_d), .rd_lanes(rd_a1));
  feeder_lane_buffer #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .K(K), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) u_buf_b0 (
    .clk(clk), .rst(rst), .wr_en(accept && !wr_sel_q), .wr_idx(beat_cnt_q),
    .wr_data(bus.in_b), .rd_t(t_d), .rd_lanes(rd_b0));
  feeder_lane_buffer #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .K(K), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) u_buf_b1 (
    .clk(clk), .rst(rst), .wr_en(accept && wr_sel_q), .wr_idx(beat_cnt_q),
    .wr_data(bus.in_b), .rd_t(t_d), .rd_lanes(rd_b1));

  assign rd_a = rd_sel_d ? rd_a1 : rd_a0;
  assign rd_b = rd_sel_d ? rd_b1 : rd_b0;
`else
  feeder_lane_buffer #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .K(K), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) u_buf_a (
    .clk(clk), .rst(rst), .wr_en(accept), .wr_idx(beat_cnt_q),
    .wr_data(bus.in_a), .rd_t(t_d), .rd_lanes(rd_a));
  feeder_lane_buffer #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .K(K), .CNT_W(CNT_W), .BEAT_W(BEAT_W)) u_buf_b (
    .clk(clk), .rst(rst), .wr_en(accept), .wr_idx(beat_cnt_q),
    .wr_data(bus.in_b), .rd_t(t_d), .rd_lanes(rd_b));
`endif

  // Next state, counters and the output values for the cycle being entered.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    t_d        = t_q;
`ifdef FEEDER_PINGPONG_EN
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    idle_full_d = idle_full_q || last_beat;
`endif

    if (accept) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
    end

    case (state_q)
      LOAD: begin
        t_d = '0;
`ifdef FEEDER_PINGPONG_EN
        if (idle_full_d) begin
          state_d     = STREAM;
          rd_sel_d    = wr_sel_q;
          wr_sel_d    = !wr_sel_q;
          idle_full_d = 1'b0;
        end
`else
        if (last_beat) begin
          state_d = STREAM;
        end
`endif
      end
      STREAM: begin
        if (t_q == T_LAST) begin
          t_d = '0;
`ifdef FEEDER_PINGPONG_EN
          // A fully loaded idle buffer starts the next tile with no LOAD gap.
          if (idle_full_d) begin
            rd_sel_d    = wr_sel_q;
            wr_sel_d    = !wr_sel_q;
            idle_full_d = 1'b0;
          end else begin
            state_d = LOAD;
          end
`else
          state_d = LOAD;
`endif
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      default: state_d = LOAD;
    endcase

`ifdef FEEDER_PINGPONG_EN
    in_ready_d = !idle_full_d;
`else
    in_ready_d = (state_d == LOAD);
`endif
    out_active_d = (state_d == STREAM);
    tile_start_d = out_active_d && (t_d == '0);
    tile_done_d  = out_active_d && (t_d == T_LAST);
    out_left_d   = out_active_d ? rd_a : '0;
    out_up_d     = out_active_d ? rd_b : '0;
  end

  // State and registered outputs; reset clears everything except in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      beat_cnt_q   <= '0;
      t_q          <= '0;
      in_ready_q   <= 1'b1;
      out_active_q <= 1'b0;
      tile_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
      out_left_q   <= '0;
      out_up_q     <= '0;
`ifdef FEEDER_PINGPONG_EN
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      idle_full_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      t_q          <= t_d;
      in_ready_q   <= in_ready_d;
      out_active_q <= out_active_d;
      tile_start_q <= tile_start_d;
      tile_done_q  <= tile_done_d;
      out_left_q   <= out_left_d;
      out_up_q     <= out_up_d;
`ifdef FEEDER_PINGPONG_EN
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      idle_full_q  <= idle_full_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_active = out_active_q;
  assign bus.tile_start = tile_start_q;
  assign bus.tile_done  = tile_done_q;
  assign bus.out_left   = out_left_q;
  assign bus.out_up     = out_up_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// tb/tb_operand_skew_feeder.sv - directed bench for operand_skew_feeder (SIZE=4,K=4 and SIZE=1,K=1)
module tb_operand_skew_feeder;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

`ifdef FEEDER_PINGPONG_EN
  localparam int FEED_MODE = 2;
`else
  localparam int FEED_MODE = 1;
`endif

  operand_skew_feeder_if #(.SIZE(4), .DATA_WIDTH(16)) bus4 ();
  operand_skew_feeder_if #(.SIZE(1), .DATA_WIDTH(16)) bus1 ();

  operand_skew_feeder #(.SIZE(4), .DATA_WIDTH(16), .K(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  operand_skew_feeder #(.SIZE(1), .DATA_WIDTH(16), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Beat n of a tile: lane k holds base + 10n + k.
  function automatic logic [63:0] beat_vec(input int base, input int n);
    logic [63:0] v;
    for (int k = 1; k <= 4; k++) v[(k-1)*16 +: 16] = 16'(base + 10*n + k);
    return v;
  endfunction

  // Lane k at stream cycle t shows beat t-(4-k) when that beat exists, else zero.
  function automatic logic [63:0] exp_vec(input int base, input int t);
    logic [63:0] v;
    int j;
    v = '0;
    for (int k = 1; k <= 4; k++) begin
      j = t - (4 - k);
      if (j >= 0 && j < 4) v[(k-1)*16 +: 16] = 16'(base + 10*j + k);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int base, input int n);
    bus4.in_valid = 1'b1;
    bus4.in_a     = beat_vec(base, n);
    bus4.in_b     = beat_vec(base + 256, n);
  endtask

  task automatic drive_idle();
    bus4.in_valid = 1'b0;
    bus4.in_a     = {4{16'hDEAD}};
    bus4.in_b     = {4{16'hBEEF}};
  endtask

  task automatic check_load(input string tag);
    check_bit({tag, "_ready"}, bus4.in_ready, 1'b1);
    check_bit({tag, "_active"}, bus4.out_active, 1'b0);
    check_bit({tag, "_start"}, bus4.tile_start, 1'b0);
    check_bit({tag, "_done"}, bus4.tile_done, 1'b0);
    check_vec({tag, "_left"}, bus4.out_left, 64'h0);
    check_vec({tag, "_up"}, bus4.out_up, 64'h0);
  endtask

  task automatic load_tile(input int base, input bit gaps);
    logic [5:0] pat;
    int len;
    int n;
    pat = gaps ? 6'b101101 : 6'b001111;
    len = gaps ? 6 : 4;
    n   = 0;
    for (int i = 0; i < len; i++) begin
      check_bit("load_ready", bus4.in_ready, 1'b1);
      check_bit("load_active", bus4.out_active, 1'b0);
      if (pat[i]) begin
        drive_beat(base, n);
        n++;
      end else begin
        drive_idle();
      end
      tick();
    end
    drive_idle();
  endtask

  // mode 0: idle inputs; 1: in_valid held with next tile beat 0; 2: load next tile at t=0..3.
  task automatic stream_check(input int base, input int mode, input int stop_at);
    logic exp_rdy;
    for (int t = 0; t < 7; t++) begin
      check_vec("stream_left", bus4.out_left, exp_vec(base, t));
      check_vec("stream_up", bus4.out_up, exp_vec(base + 256, t));
      check_bit("stream_active", bus4.out_active, 1'b1);
      check_bit("stream_start", bus4.tile_start, t == 0);
      check_bit("stream_done", bus4.tile_done, t == 6);
`ifdef FEEDER_PINGPONG_EN
      exp_rdy = (mode == 2) ? (t <= 3) : 1'b1;
`else
      exp_rdy = 1'b0;
`endif
      check_bit("stream_ready", bus4.in_ready, exp_rdy);
      if (base == 0 && t == 0) check_vec("lit_t0", bus4.out_left, 64'h0004_0000_0000_0000);
      if (base == 0 && t == 3) check_vec("lit_t3", bus4.out_left, 64'h0022_0017_000C_0001);
      if (base == 0 && t == 6) check_vec("lit_t6", bus4.out_left, 64'h0000_0000_0000_001F);
      if (t == stop_at) return;
      case (mode)
        1:       drive_beat(50, 0);
        2:       if (t < 4) drive_beat(50, t); else drive_idle();
        default: drive_idle();
      endcase
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    bus1.in_valid = 1'b0;
    bus1.in_a     = '0;
    bus1.in_b     = '0;
    tick();
    tick();
    check_bit("rst_active", bus4.out_active, 1'b0);
    check_bit("rst_start", bus4.tile_start, 1'b0);
    check_bit("rst_done", bus4.tile_done, 1'b0);
    check_vec("rst_left", bus4.out_left, 64'h0);
    check_vec("rst_left1", 64'(bus1.out_left), 64'h0);
    rst = 1'b0;
    tick();
    check_load("post_reset");

    load_tile(0, 1'b1);
    stream_check(0, FEED_MODE, -1);
`ifdef FEEDER_PINGPONG_EN
    stream_check(50, 0, -1);
`else
    check_load("held_load");
    tick();
    for (int n = 1; n < 4; n++) begin
      drive_beat(50, n);
      tick();
    end
    drive_idle();
    stream_check(50, 0, -1);
`endif
    check_load("after_tiles");

    load_tile(20, 1'b0);
    stream_check(20, 0, 2);
    rst = 1'b1;
    #1;
    check_vec("midrst_left", bus4.out_left, 64'h0);
    check_vec("midrst_up", bus4.out_up, 64'h0);
    check_bit("midrst_active", bus4.out_active, 1'b0);
    check_bit("midrst_start", bus4.tile_start, 1'b0);
    check_bit("midrst_done", bus4.tile_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_load("post_mid_reset");
    load_tile(30, 1'b0);
    stream_check(30, 0, -1);
    check_load("after_reset_tile");

    check_bit("k1_ready", bus1.in_ready, 1'b1);
    bus1.in_valid = 1'b1;
    bus1.in_a     = 16'h1234;
    bus1.in_b     = 16'h5678;
    tick();
    bus1.in_valid = 1'b0;
    check_vec("k1_left", 64'(bus1.out_left), 64'h1234);
    check_vec("k1_up", 64'(bus1.out_up), 64'h5678);
    check_bit("k1_start", bus1.tile_start, 1'b1);
    check_bit("k1_done", bus1.tile_done, 1'b1);
    check_bit("k1_active", bus1.out_active, 1'b1);
    tick();
    check_bit("k1_after_active", bus1.out_active, 1'b0);
    check_vec("k1_after_left", 64'(bus1.out_left), 64'h0);
    check_bit("k1_after_ready", bus1.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
